// File: rtl/axis_sa_pkg.sv
// Shared types and helpers for the systolic-array output sink.
// Bank state encoding and counter-width helper used by the top and the tile bank.
package axis_sa_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    localparam int NUM_BANKS = 2;

    // A counter over n positions needs at least one bit even when n == 1.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sa_tile_bank.sv
// One R x C tile buffer: written a column at a time, read a row at a time.
// Columns never written since the last clear read back as zero.
module sa_tile_bank
    import axis_sa_pkg::*;
#(
    parameter  int R  = 4,
    parameter  int C  = 8,
    parameter  int WY = 16,
    localparam int CW = clog2_min1(C),
    localparam int RW = clog2_min1(R)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   we,
    input  logic [CW-1:0]          col,
    input  logic [R-1:0][WY-1:0]   wdata,
    input  logic                   clr,
    input  logic [RW-1:0]          row,
    output logic [C-1:0][WY-1:0]   rdata
);

    logic [WY-1:0] r_mem [R][C];
    logic [C-1:0]  r_mask;
    logic [C-1:0]  w_set;

    // NOTE: the word array has no reset; validity is tracked by the mask alone,
    // so reset only needs to clear C flops instead of the whole storage.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int r = 0; r < R; r++) begin
                r_mem[r][col] <= wdata[r];
            end
        end
    end

    assign w_set = we ? (C'(1) << col) : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mask <= '0;
        end else if (clr || we) begin
            r_mask <= (clr ? '0 : r_mask) | w_set;
        end
    end

    always_comb begin
        for (int c = 0; c < C; c++) begin
            rdata[c] = r_mask[c] ? r_mem[row][c] : '0;
        end
    end

endmodule

// File: rtl/axis_sa_sink.sv
// Ping-pong tile buffer: accepts column beats from the systolic array and
// re-emits each tile transposed as row beats on a downstream AXI Stream.
module axis_sa_sink
    import axis_sa_pkg::*;
#(
    parameter int R  = 4,
    parameter int C  = 8,
    parameter int WY = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   s_last,
    input  logic [R-1:0][WY-1:0]   s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic [C-1:0][WY-1:0]   m_data,
    output logic                   err
);

    localparam int            CW       = clog2_min1(C);
    localparam int            RW       = clog2_min1(R);
    localparam logic [CW-1:0] COL_LAST = CW'(C - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(R - 1);

    bank_state_t r_state     [NUM_BANKS];
    bank_state_t w_state_nxt [NUM_BANKS];

    logic          r_wb;
    logic          r_rb;
    logic [CW-1:0] r_wcol;
    logic [RW-1:0] r_rrow;
    logic          r_err;

    logic          w_wr_fire;
    logic          w_col_end;
    logic          w_close;
    logic          w_rd_fire;
    logic          w_rd_done;

    logic [C-1:0][WY-1:0] w_bank_rdata [NUM_BANKS];

    assign w_wr_fire = s_valid && s_ready;
    assign w_col_end = (r_wcol == COL_LAST);
    assign w_close   = w_wr_fire && (s_last || w_col_end);
    assign w_rd_fire = m_valid && m_ready;
    assign w_rd_done = w_rd_fire && m_last;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        sa_tile_bank #(
            .R  (R),
            .C  (C),
            .WY (WY)
        ) u_bank (
            .clk   (clk),
            .rstn  (rstn),
            .we    (w_wr_fire && (r_wb == 1'(b))),
            .col   (r_wcol),
            .wdata (s_data),
            .clr   (w_rd_done && (r_rb == 1'(b))),
            .row   (r_rrow),
            .rdata (w_bank_rdata[b])
        );
    end

    // NOTE: every flop below takes non-blocking assignments so all state moves
    // together on the edge regardless of the order the statements appear in.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_state[b] <= EMPTY;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_state[b] <= w_state_nxt[b];
            end
        end
    end

    // The write bank is only ever EMPTY/FILLING and the read bank FULL/DRAINING,
    // so both updates can land on the same edge without touching the same bank.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            // NOTE: hold-value default first, so no path leaves the next state unassigned.
            w_state_nxt[b] = r_state[b];
            if (w_wr_fire && (r_wb == 1'(b))) begin
                w_state_nxt[b] = w_close ? FULL : FILLING;
            end
            if (w_rd_fire && (r_rb == 1'(b))) begin
                w_state_nxt[b] = w_rd_done ? EMPTY : DRAINING;
            end
        end
    end

    always_comb begin
        s_ready = (r_state[r_wb] == EMPTY) || (r_state[r_wb] == FILLING);
        m_valid = (r_state[r_rb] == FULL)  || (r_state[r_rb] == DRAINING);
        m_last  = m_valid && (r_rrow == ROW_LAST);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wb   <= 1'b0;
            r_wcol <= '0;
            r_rb   <= 1'b0;
            r_rrow <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                if (w_close) begin
                    r_wcol <= '0;
                    r_wb   <= ~r_wb;
                end else begin
                    r_wcol <= r_wcol + CW'(1);
                end
                // Early s_last (short tile) or missing s_last on the final column.
                if (s_last != w_col_end) begin
                    r_err <= 1'b1;
                end
            end
            if (w_rd_fire) begin
                if (w_rd_done) begin
                    r_rrow <= '0;
                    r_rb   <= ~r_rb;
                end else begin
                    r_rrow <= r_rrow + RW'(1);
                end
            end
        end
    end

    assign m_data = m_valid ? w_bank_rdata[r_rb] : '0;
    assign err    = r_err;

endmodule

// File: tb/tb_axis_sa_sink.sv
// Self-checking bench for axis_sa_sink: a per-cycle vector table for the basic
// tile, then scoreboard-driven sequences for back-pressure, framing, reset and random traffic.
module tb_axis_sa_sink;

    localparam int R  = 4;
    localparam int C  = 8;
    localparam int WY = 16;
    localparam int DW = C * WY;
    localparam int IW = R * WY;

    logic                 clk     = 1'b0;
    logic                 rstn    = 1'b0;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic                 s_last  = 1'b0;
    logic [R-1:0][WY-1:0] s_data  = '0;
    logic                 m_valid;
    logic                 m_ready = 1'b0;
    logic                 m_last;
    logic [C-1:0][WY-1:0] m_data;
    logic                 err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_in     = 0;
    int n_out    = 0;

    logic [IW-1:0] in_data_q  [$];
    bit            in_last_q  [$];
    logic [DW-1:0] exp_data_q [$];
    bit            exp_last_q [$];

    bit            held = 1'b0;
    logic [DW-1:0] held_data;
    logic          held_last;

    typedef struct {
        bit sv;
        bit sl;
        int col;
        bit mr;
        bit e_srdy;
        bit e_mval;
        bit e_mlast;
        int e_row;
        bit e_err;
    } vec_t;

    vec_t vt [13];

    axis_sa_sink #(.R(R), .C(C), .WY(WY)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_last  (s_last),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last),
        .m_data  (m_data),
        .err     (err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [WY-1:0] word(input int t, input int r, input int c);
        return WY'(t * 256 + r * 16 + c);
    endfunction

    function automatic vec_t mk(input bit sv, input bit sl, input int col, input bit mr,
                                input bit e_srdy, input bit e_mval, input bit e_mlast,
                                input int e_row, input bit e_err);
        vec_t v;
        v.sv = sv; v.sl = sl; v.col = col; v.mr = mr;
        v.e_srdy = e_srdy; v.e_mval = e_mval; v.e_mlast = e_mlast;
        v.e_row = e_row; v.e_err = e_err;
        return v;
    endfunction

    // Queue a tile of len columns; len < C models a short tile closed by s_last.
    task automatic push_tile(input int t, input int len);
        logic [R-1:0][WY-1:0] colv;
        logic [C-1:0][WY-1:0] rowv;
        for (int c = 0; c < len; c++) begin
            for (int r = 0; r < R; r++) colv[r] = word(t, r, c);
            in_data_q.push_back(colv);
            in_last_q.push_back(c == len - 1);
        end
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) rowv[c] = (c < len) ? word(t, r, c) : '0;
            exp_data_q.push_back(rowv);
            exp_last_q.push_back(r == R - 1);
        end
    endtask

    // One cycle: drive inputs just after the edge, check outputs, and book the
    // handshakes that the coming edge will perform.
    task automatic step(input bit v_en, input bit rdy, input bit chk_srdy);
        bit in_fire;
        bit out_fire;
        @(posedge clk);
        #1;
        s_valid = v_en && (in_data_q.size() > 0);
        s_data  = s_valid ? in_data_q[0] : '0;
        s_last  = s_valid ? in_last_q[0] : 1'b0;
        m_ready = rdy;
        if (held) begin
            check("stall_data", m_data, held_data);
            check("stall_last", m_last, held_last);
        end
        held      = m_valid && !m_ready;
        held_data = m_data;
        held_last = m_last;
        if (chk_srdy && s_valid) check("s_ready_high", s_ready, 1'b1);
        in_fire  = s_valid && s_ready;
        out_fire = m_valid && m_ready;
        if (in_fire) begin
            in_data_q.delete(0);
            in_last_q.delete(0);
            n_in++;
        end
        if (out_fire) begin
            check("out_has_expected", exp_data_q.size() != 0, 1'b1);
            if (exp_data_q.size() != 0) begin
                check("out_data", m_data, exp_data_q[0]);
                check("out_last", m_last, exp_last_q[0]);
                exp_data_q.delete(0);
                exp_last_q.delete(0);
            end
            n_out++;
        end
    endtask

    task automatic drain(input string name, input int budget, input bit rnd, input bit chk_srdy);
        for (int i = 0; i < budget && (in_data_q.size() + exp_data_q.size()) > 0; i++) begin
            if (rnd) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), chk_srdy);
            else     step(1'b1, 1'b1, chk_srdy);
        end
        check({name, "_drained"}, in_data_q.size() + exp_data_q.size(), 0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_s_ready"}, s_ready, 1'b1);
        check({name, "_m_valid"}, m_valid, 1'b0);
        check({name, "_m_last"},  m_last,  1'b0);
        check({name, "_m_data"},  m_data,  '0);
        check({name, "_err"},     err,     1'b0);
    endtask

    initial begin
        int base;
        logic [C-1:0][WY-1:0] erow;

        //            sv sl col mr  srdy mval mlast row err
        vt[0]  = mk(1, 0, 0, 1,  1,   0,   0,    0,  0);
        vt[1]  = mk(1, 0, 1, 1,  1,   0,   0,    0,  0);
        vt[2]  = mk(1, 0, 2, 1,  1,   0,   0,    0,  0);
        vt[3]  = mk(1, 0, 3, 1,  1,   0,   0,    0,  0);
        vt[4]  = mk(1, 0, 4, 1,  1,   0,   0,    0,  0);
        vt[5]  = mk(1, 0, 5, 1,  1,   0,   0,    0,  0);
        vt[6]  = mk(1, 0, 6, 1,  1,   0,   0,    0,  0);
        vt[7]  = mk(1, 1, 7, 1,  1,   0,   0,    0,  0);
        vt[8]  = mk(0, 0, 0, 1,  1,   1,   0,    0,  0);
        vt[9]  = mk(0, 0, 0, 1,  1,   1,   0,    1,  0);
        vt[10] = mk(0, 0, 0, 1,  1,   1,   0,    2,  0);
        vt[11] = mk(0, 0, 0, 1,  1,   1,   1,    3,  0);
        vt[12] = mk(0, 0, 0, 1,  1,   0,   0,    0,  0);

        #3;
        check_reset_values("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Single tile, data 16*r+c, one check set per cycle.
        for (int k = 0; k < 13; k++) begin
            @(posedge clk);
            #1;
            s_valid = vt[k].sv;
            s_last  = vt[k].sl;
            for (int r = 0; r < R; r++) s_data[r] = vt[k].sv ? word(0, r, vt[k].col) : '0;
            m_ready = vt[k].mr;
            check($sformatf("t1_s_ready_%0d", k), s_ready, vt[k].e_srdy);
            check($sformatf("t1_m_valid_%0d", k), m_valid, vt[k].e_mval);
            check($sformatf("t1_m_last_%0d", k),  m_last,  vt[k].e_mlast);
            check($sformatf("t1_err_%0d", k),     err,     vt[k].e_err);
            if (vt[k].e_mval) begin
                for (int c = 0; c < C; c++) erow[c] = word(0, vt[k].e_row, c);
                check($sformatf("t1_m_data_%0d", k), m_data, erow);
            end
        end

        // Three back-to-back tiles; s_ready must never drop.
        base = n_out;
        push_tile(1, C);
        push_tile(2, C);
        push_tile(3, C);
        drain("b2b", 200, 1'b0, 1'b1);
        check("b2b_out_count", n_out - base, 3 * R);

        // Downstream stalled: two tiles fill both banks, then s_ready drops.
        push_tile(4, C);
        push_tile(5, C);
        push_tile(6, C);
        base = n_in;
        for (int i = 0; i < 3 * C; i++) step(1'b1, 1'b0, 1'b0);
        check("full_accept_count", n_in - base, 2 * C);
        check("full_s_ready_low", s_ready, 1'b0);
        base = n_out;
        for (int i = 0; i < 40 && (n_out - base) < R; i++) step(1'b1, 1'b1, 1'b0);
        check("full_first_tile_out", n_out - base, R);
        check("full_s_ready_at_last", s_ready, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        drain("full", 200, 1'b0, 1'b0);

        // Short tile (s_last on column 4) followed by a well-formed tile.
        check("short_err_before", err, 1'b0);
        push_tile(7, 5);
        push_tile(8, C);
        drain("short", 200, 1'b0, 1'b0);
        check("short_err_sticky", err, 1'b1);

        // Reset after two output beats of a tile.
        push_tile(9, C);
        base = n_out;
        for (int i = 0; i < 60 && (n_out - base) < 2; i++) step(1'b1, 1'b1, 1'b0);
        check("rst_two_beats_out", n_out - base, 2);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        check("rst_pre_m_valid", m_valid, 1'b1);
        rstn = 1'b0;
        #1;
        check_reset_values("midrst");
        in_data_q.delete();
        in_last_q.delete();
        exp_data_q.delete();
        exp_last_q.delete();
        held = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        push_tile(10, C);
        drain("post_rst", 200, 1'b0, 1'b0);

        // Random traffic on both sides against the scoreboard.
        for (int t = 0; t < 100; t++) push_tile(11 + t, C);
        drain("random", 20000, 1'b1, 1'b0);
        check("random_err", err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
